// File: rtl/binary_divider_seq_if.sv
// Handshake and operand/result bundle for the 8-by-4 sequential divider.
// The requester drives start and operands; the divider returns results and status.
interface binary_divider_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/binary_divider_seq.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per clock.
// IDLE accepts a request, RUN iterates 8 times MSB first, DONE presents the result for one cycle.
module binary_divider_seq (
    input  logic                  clk,
    input  logic                  rst,
    binary_divider_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] dividend_reg, dividend_next;
    logic [3:0] divisor_reg, divisor_next;
    logic [4:0] p_reg, p_next;
    logic [7:0] q_reg, q_next;
    logic [2:0] count_reg, count_next;
    logic [7:0] quotient_reg, quotient_next;
    logic [3:0] remainder_reg, remainder_next;
    logic       dbz_reg, dbz_next;

    logic [4:0] p_shift;
    logic [4:0] p_sub;
    logic       q_bit;
    logic [4:0] p_step;
    logic [7:0] q_step;

    // One restoring step; the working dividend shifts left so bit 7 is always the next bit.
    always_comb begin
        p_shift = {p_reg[3:0], dividend_reg[7]};
        p_sub   = p_shift - {1'b0, divisor_reg};
        q_bit   = (p_shift >= {1'b0, divisor_reg});
        p_step  = q_bit ? p_sub : p_shift;
        q_step  = {q_reg[6:0], q_bit};
    end

    always_comb begin
        state_next     = state_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        p_next         = p_reg;
        q_next         = q_reg;
        count_next     = count_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    dividend_next  = bus.dividend;
                    divisor_next   = bus.divisor;
                    p_next         = 5'd0;
                    q_next         = 8'd0;
                    count_next     = 3'd0;
                    remainder_next = 4'd0;
                    if (bus.divisor == 4'd0) begin
                        state_next    = DONE;
                        quotient_next = 8'hFF;
                        dbz_next      = 1'b1;
                    end else begin
                        state_next    = RUN;
                        quotient_next = 8'd0;
                        dbz_next      = 1'b0;
                    end
                end
            end
            RUN: begin
                p_next        = p_step;
                q_next        = q_step;
                dividend_next = {dividend_reg[6:0], 1'b0};
                count_next    = count_reg + 3'd1;
                // Results reach the outputs only on the final step.
                if (count_reg == 3'd7) begin
                    state_next     = DONE;
                    quotient_next  = q_step;
                    remainder_next = p_step[3:0];
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dividend_reg  <= 8'd0;
            divisor_reg   <= 4'd0;
            p_reg         <= 5'd0;
            q_reg         <= 8'd0;
            count_reg     <= 3'd0;
            quotient_reg  <= 8'd0;
            remainder_reg <= 4'd0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            p_reg         <= p_next;
            q_reg         <= q_next;
            count_reg     <= count_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
endmodule
